// File: rtl/multicycle_seq_pkg.sv
//==============================================================================
//  Module      : multicycle_seq_pkg
//  Description : Shared definitions for the multicycle control sequencer:
//                state encodings, opcode/funct constants, pc_src and mem_size
//                codes, the instruction-class enum and a size helper.
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package multicycle_seq_pkg;

    // Sequencer states; encodings 7 and above are unused and recover to fetch
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_ALU_R   = 4'd1,
        CLS_JR      = 4'd2,
        CLS_ALU_I   = 4'd3,
        CLS_LOAD    = 4'd4,
        CLS_STORE   = 4'd5,
        CLS_BRANCH  = 4'd6,
        CLS_J       = 4'd7,
        CLS_JAL     = 4'd8
    } cls_t;

    // Opcodes
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_slti  = 6'b001010;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_lb    = 6'b100000;
    localparam logic [5:0] c_op_lh    = 6'b100001;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sb    = 6'b101000;
    localparam logic [5:0] c_op_sh    = 6'b101001;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_bgez  = 6'b000001;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;

    // R-type function codes
    localparam logic [5:0] c_fn_jr    = 6'b001000;

    // PC source select
    localparam logic [1:0] c_pc_plus4  = 2'd0;
    localparam logic [1:0] c_pc_branch = 2'd1;
    localparam logic [1:0] c_pc_jump   = 2'd2;
    localparam logic [1:0] c_pc_reg    = 2'd3;

    // Memory transfer size
    localparam logic [1:0] c_sz_byte = 2'd1;
    localparam logic [1:0] c_sz_half = 2'd2;
    localparam logic [1:0] c_sz_word = 2'd3;

    // Load/store width from the low opcode bits (00 byte, 01 half, 11 word)
    function automatic logic [1:0] mem_size_of(input logic [1:0] op_lo);
        case (op_lo)
            2'b00:   return c_sz_byte;
            2'b01:   return c_sz_half;
            default: return c_sz_word;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_seq_decode.sv
//==============================================================================
//  Module      : seq_decode
//  Description : Maps the IR opcode and funct fields to an instruction class.
//                Any opcode outside the supported set decodes as illegal.
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_decode
    import multicycle_seq_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output cls_t       cls
);

    // Pure combinational opcode classification
    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            c_op_rtype: cls = (funct == c_fn_jr) ? CLS_JR : CLS_ALU_R;
            c_op_addi, c_op_andi, c_op_ori,
            c_op_slti, c_op_lui:             cls = CLS_ALU_I;
            c_op_lb, c_op_lh, c_op_lw:       cls = CLS_LOAD;
            c_op_sb, c_op_sh, c_op_sw:       cls = CLS_STORE;
            c_op_beq, c_op_bne, c_op_bgez:   cls = CLS_BRANCH;
            c_op_j:                          cls = CLS_J;
            c_op_jal:                        cls = CLS_JAL;
            default:                         cls = CLS_ILLEGAL;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_seq.sv
//==============================================================================
//  Module      : multicycle_seq
//  Description : Multicycle CPU control sequencer (fetch/decode/exec/mem/wb)
//                with terminal trap and fault states. Strobes are decoded
//                from the current state (and mem_ready where a transfer
//                completes) and forced to 0 while reset is high, so the
//                first cycle after reset already issues the fetch request.
//                Optional memory-wait watchdog enabled by defining TIMEOUT_EN.
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module multicycle_seq
    import multicycle_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] mem_size,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [2:0] state,
    output logic       retire,
    output logic       trap,
    output logic       fault
);

    state_t     r_state;
    state_t     w_next;
    cls_t       r_class;
    cls_t       w_class;
    logic       r_trap;
    logic       w_timeout;

    logic       w_mem_req;
    logic       w_mem_we;
    logic [1:0] w_mem_size;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic [1:0] w_pc_src;
    logic       w_reg_write;
    logic       w_retire;

    seq_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (w_class)
    );

    // Next-state selection; a completing mem_ready always beats the watchdog
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_DECODE: begin
                case (w_class)
                    CLS_ILLEGAL:     w_next = S_TRAP;
                    CLS_J, CLS_JAL:  w_next = S_FETCH;
                    default:         w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (r_class)
                    CLS_BRANCH, CLS_JR:    w_next = S_FETCH;
                    CLS_LOAD, CLS_STORE:   w_next = S_MEM;
                    default:               w_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready)      w_next = (r_class == CLS_STORE) ? S_FETCH : S_WB;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_WB:    w_next = S_FETCH;
            S_TRAP:  w_next = S_TRAP;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FETCH;
        endcase
    end

    // Strobe decode of the current state; trap/fault states drive nothing
    always_comb begin
        w_mem_req       = 1'b0;
        w_mem_we        = 1'b0;
        w_mem_size      = 2'd0;
        w_ir_write      = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_pc_src        = c_pc_plus4;
        w_reg_write     = 1'b0;
        w_retire        = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req  = 1'b1;
                w_mem_size = c_sz_word;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_pc_src   = c_pc_plus4;
                end
            end
            S_DECODE: begin
                if (w_class == CLS_J || w_class == CLS_JAL) begin
                    w_pc_write  = 1'b1;
                    w_pc_src    = c_pc_jump;
                    w_retire    = 1'b1;
                    w_reg_write = (w_class == CLS_JAL);
                end
            end
            S_EXEC: begin
                if (r_class == CLS_BRANCH) begin
                    w_pc_write_cond = 1'b1;
                    w_pc_src        = c_pc_branch;
                    w_retire        = 1'b1;
                end else if (r_class == CLS_JR) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = c_pc_reg;
                    w_retire   = 1'b1;
                end
            end
            S_MEM: begin
                w_mem_req  = 1'b1;
                w_mem_we   = (r_class == CLS_STORE);
                w_mem_size = mem_size_of(opcode[1:0]);
                w_retire   = mem_ready && (r_class == CLS_STORE);
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Sequencer state, latched instruction class and sticky trap flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_class <= CLS_ILLEGAL;
            r_trap  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_class <= w_class;
            if (w_next == S_TRAP)    r_trap  <= 1'b1;
        end
    end

`ifdef TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       r_fault;
    logic       w_waiting;

    assign w_waiting = w_mem_req & ~mem_ready;
    assign w_timeout = w_waiting && (r_wait_cnt == 8'(TIMEOUT_CYC - 1));

    // Wait counter restarts on every state change; fault is sticky
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= 8'd0;
            r_fault    <= 1'b0;
        end else begin
            if (w_next != r_state)  r_wait_cnt <= 8'd0;
            else if (w_waiting)     r_wait_cnt <= r_wait_cnt + 8'd1;
            if (w_next == S_FAULT)  r_fault    <= 1'b1;
        end
    end

    assign fault = reset ? 1'b0 : r_fault;
`else
    // Without the watchdog, waits are unbounded and the limit is unused
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT_CYC);
    assign w_timeout        = 1'b0;
    assign fault            = 1'b0;
`endif

    assign mem_req       = reset ? 1'b0 : w_mem_req;
    assign mem_we        = reset ? 1'b0 : w_mem_we;
    assign mem_size      = reset ? 2'd0 : w_mem_size;
    assign ir_write      = reset ? 1'b0 : w_ir_write;
    assign pc_write      = reset ? 1'b0 : w_pc_write;
    assign pc_write_cond = reset ? 1'b0 : w_pc_write_cond;
    assign pc_src        = reset ? 2'd0 : w_pc_src;
    assign reg_write     = reset ? 1'b0 : w_reg_write;
    assign retire        = reset ? 1'b0 : w_retire;
    assign state         = reset ? 3'd0 : r_state;
    assign trap          = reset ? 1'b0 : r_trap;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_seq.sv
//==============================================================================
//  Module      : tb_multicycle_seq
//  Description : Directed self-checking bench for multicycle_seq. Each cycle's
//                expected output vector is queued as stimulus is applied and
//                popped when the outputs are sampled mid-cycle. The watchdog
//                steps follow TIMEOUT_EN.
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_multicycle_seq;

    localparam logic [2:0] FE = 3'd0, DE = 3'd1, EX = 3'd2, ME = 3'd3,
                           WB = 3'd4, TR = 3'd5, FA = 3'd6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, ir_write, pc_write, pc_write_cond;
    logic       reg_write, retire, trap, fault;
    logic [1:0] mem_size, pc_src;
    logic [2:0] state;

    multicycle_seq #(.TIMEOUT_CYC(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_size      (mem_size),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .state         (state),
        .retire        (retire),
        .trap          (trap),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {mem_req, mem_we, mem_size, ir_write, pc_write, pc_write_cond,
                  pc_src, reg_write, state, retire, trap, fault};

    typedef struct {
        string       tag;
        logic [15:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Expected vector: req we size irw pcw pcc src rw state ret trap fault
    function automatic logic [15:0] o(input logic req, input logic we,
                                      input logic [1:0] sz, input logic irw,
                                      input logic pcw, input logic pcc,
                                      input logic [1:0] src, input logic rw,
                                      input logic [2:0] st, input logic ret,
                                      input logic trp, input logic flt);
        return {req, we, sz, irw, pcw, pcc, src, rw, st, ret, trp, flt};
    endfunction

    function automatic logic [15:0] fetch(input logic rdy);
        return o(1'b1, 1'b0, 2'd3, rdy, rdy, 1'b0, 2'd0, 1'b0, FE, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [15:0] idle(input logic [2:0] st, input logic trp,
                                         input logic flt);
        return o(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, st, 1'b0, trp, flt);
    endfunction

    // One clock cycle: apply mem_ready, queue expectation, check mid-cycle
    task automatic cyc(input logic rdy, input string tag, input logic [15:0] e);
        exp_t s;
        exp_t p;
        mem_ready = rdy;
        s.tag = tag;
        s.v   = e;
        sb_q.push_back(s);
        @(negedge clk);
        p = sb_q.pop_front();
        checks++;
        assert (obs === p.v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", p.tag, obs, p.v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset holds every output low even with mem_ready high
        cyc(1'b1, "reset_outputs", idle(FE, 1'b0, 1'b0));
        reset = 1'b0;

        // add: fetch, decode, exec, wb
        load_ir(6'b000000, 6'b100000);
        cyc(1'b1, "add_fetch",  fetch(1'b1));
        cyc(1'b1, "add_decode", idle(DE, 1'b0, 1'b0));
        cyc(1'b1, "add_exec",   idle(EX, 1'b0, 1'b0));
        cyc(1'b1, "add_wb",     o(0, 0, 2'd0, 0, 0, 0, 2'd0, 1, WB, 1, 0, 0));

        // lw: fetch ready on third cycle, data ready immediately
        load_ir(6'b100011, 6'd0);
        cyc(1'b0, "lw_fetch_w1", fetch(1'b0));
        cyc(1'b0, "lw_fetch_w2", fetch(1'b0));
        cyc(1'b1, "lw_fetch_rd", fetch(1'b1));
        cyc(1'b0, "lw_decode",   idle(DE, 1'b0, 1'b0));
        cyc(1'b0, "lw_exec",     idle(EX, 1'b0, 1'b0));
        cyc(1'b1, "lw_mem",      o(1, 0, 2'd3, 0, 0, 0, 2'd0, 0, ME, 0, 0, 0));
        cyc(1'b0, "lw_wb",       o(0, 0, 2'd0, 0, 0, 0, 2'd0, 1, WB, 1, 0, 0));

        // sb: three wait cycles in fetch and in mem, counter restarts between
        load_ir(6'b101000, 6'd0);
        cyc(1'b0, "sb_fetch_w1", fetch(1'b0));
        cyc(1'b0, "sb_fetch_w2", fetch(1'b0));
        cyc(1'b0, "sb_fetch_w3", fetch(1'b0));
        cyc(1'b1, "sb_fetch_rd", fetch(1'b1));
        cyc(1'b0, "sb_decode",   idle(DE, 1'b0, 1'b0));
        cyc(1'b0, "sb_exec",     idle(EX, 1'b0, 1'b0));
        cyc(1'b0, "sb_mem_w1",   o(1, 1, 2'd1, 0, 0, 0, 2'd0, 0, ME, 0, 0, 0));
        cyc(1'b0, "sb_mem_w2",   o(1, 1, 2'd1, 0, 0, 0, 2'd0, 0, ME, 0, 0, 0));
        cyc(1'b0, "sb_mem_w3",   o(1, 1, 2'd1, 0, 0, 0, 2'd0, 0, ME, 0, 0, 0));
        cyc(1'b1, "sb_mem_rd",   o(1, 1, 2'd1, 0, 0, 0, 2'd0, 0, ME, 1, 0, 0));

        // beq: conditional PC write in exec
        load_ir(6'b000100, 6'd0);
        cyc(1'b1, "beq_fetch",  fetch(1'b1));
        cyc(1'b1, "beq_decode", idle(DE, 1'b0, 1'b0));
        cyc(1'b1, "beq_exec",   o(0, 0, 2'd0, 0, 0, 1, 2'd1, 0, EX, 1, 0, 0));

        // jr: register PC source in exec, no register write
        load_ir(6'b000000, 6'b001000);
        cyc(1'b1, "jr_fetch",  fetch(1'b1));
        cyc(1'b1, "jr_decode", idle(DE, 1'b0, 1'b0));
        cyc(1'b1, "jr_exec",   o(0, 0, 2'd0, 0, 1, 0, 2'd3, 0, EX, 1, 0, 0));

        // jal: retires in decode with link write
        load_ir(6'b000011, 6'd0);
        cyc(1'b1, "jal_fetch",  fetch(1'b1));
        cyc(1'b1, "jal_decode", o(0, 0, 2'd0, 0, 1, 0, 2'd2, 1, DE, 1, 0, 0));

        // j: retires in decode without link write
        load_ir(6'b000010, 6'd0);
        cyc(1'b1, "j_fetch",  fetch(1'b1));
        cyc(1'b1, "j_decode", o(0, 0, 2'd0, 0, 1, 0, 2'd2, 0, DE, 1, 0, 0));

        // lh: halfword load size
        load_ir(6'b100001, 6'd0);
        cyc(1'b1, "lh_fetch",  fetch(1'b1));
        cyc(1'b1, "lh_decode", idle(DE, 1'b0, 1'b0));
        cyc(1'b1, "lh_exec",   idle(EX, 1'b0, 1'b0));
        cyc(1'b1, "lh_mem",    o(1, 0, 2'd2, 0, 0, 0, 2'd0, 0, ME, 0, 0, 0));
        cyc(1'b1, "lh_wb",     o(0, 0, 2'd0, 0, 0, 0, 2'd0, 1, WB, 1, 0, 0));

        // addi: immediate ALU class goes through wb
        load_ir(6'b001000, 6'd0);
        cyc(1'b1, "addi_fetch",  fetch(1'b1));
        cyc(1'b1, "addi_decode", idle(DE, 1'b0, 1'b0));
        cyc(1'b1, "addi_exec",   idle(EX, 1'b0, 1'b0));
        cyc(1'b1, "addi_wb",     o(0, 0, 2'd0, 0, 0, 0, 2'd0, 1, WB, 1, 0, 0));

        // sw: reset during the mem wait abandons the instruction
        load_ir(6'b101011, 6'd0);
        cyc(1'b1, "sw_fetch",   fetch(1'b1));
        cyc(1'b1, "sw_decode",  idle(DE, 1'b0, 1'b0));
        cyc(1'b1, "sw_exec",    idle(EX, 1'b0, 1'b0));
        cyc(1'b0, "sw_mem_w1",  o(1, 1, 2'd3, 0, 0, 0, 2'd0, 0, ME, 0, 0, 0));
        reset = 1'b1;
        cyc(1'b1, "sw_in_reset", idle(FE, 1'b0, 1'b0));
        reset = 1'b0;
        cyc(1'b1, "sw_abandon", fetch(1'b1));

        // illegal opcode: decode silent, then terminal trap
        load_ir(6'b111111, 6'd0);
        cyc(1'b1, "ill_decode", idle(DE, 1'b0, 1'b0));
        cyc(1'b1, "trap_1",     idle(TR, 1'b1, 1'b0));
        cyc(1'b1, "trap_2",     idle(TR, 1'b1, 1'b0));
        load_ir(6'b000010, 6'd0);
        cyc(1'b1, "trap_3",     idle(TR, 1'b1, 1'b0));
        reset = 1'b1;
        cyc(1'b0, "trap_reset", idle(FE, 1'b0, 1'b0));
        reset = 1'b0;

        // memory never answers: watchdog limit of 4 wait cycles
        cyc(1'b0, "wait_1", fetch(1'b0));
        cyc(1'b0, "wait_2", fetch(1'b0));
        cyc(1'b0, "wait_3", fetch(1'b0));
        cyc(1'b0, "wait_4", fetch(1'b0));
`ifdef TIMEOUT_EN
        cyc(1'b1, "fault_1", idle(FA, 1'b0, 1'b1));
        cyc(1'b1, "fault_2", idle(FA, 1'b0, 1'b1));
`else
        cyc(1'b0, "wait_5", fetch(1'b0));
        cyc(1'b0, "wait_6", fetch(1'b0));
`endif
        reset = 1'b1;
        cyc(1'b0, "final_reset", idle(FE, 1'b0, 1'b0));
        reset = 1'b0;
        cyc(1'b0, "final_fetch", fetch(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
